// File: rtl/pcie_cq_rx_fifo.sv
// CQ receiver: reassembles completer-request TLPs into records and queues them.
// Optional statistics counters are enabled with `define PCIE_CQ_STAT_EN.
module pcie_cq_rx_fifo #(
    parameter int DWIDTH     = 256,
    parameter int MAX_PLD_DW = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REC_W      = 128 + 32 * MAX_PLD_DW
) (
    input  logic                   pcie_clk,
    input  logic                   pcie_rst,
    input  logic [DWIDTH-1:0]      m_axis_cq_tdata,
    input  logic [87:0]            m_axis_cq_tuser,
    input  logic [DWIDTH/32-1:0]   m_axis_cq_tkeep,
    input  logic                   m_axis_cq_tlast,
    input  logic                   m_axis_cq_tvalid,
    output logic                   m_axis_cq_tready,
    output logic [REC_W-1:0]       cq_rec_data,
    output logic [31:0]            cq_rec_ex,
    output logic                   cq_rec_valid,
    input  logic                   cq_rec_ready,
`ifdef PCIE_CQ_STAT_EN
    input  logic                   cq_stat_clr,
    output logic [63:0]            cq_stat,
`endif
    output logic [15:0]            odbg_info
);

    localparam int NK = DWIDTH / 32;
    localparam int KW = $clog2(NK);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t      state;
    logic [127:0] desc;
    logic [31:0] pld [MAX_PLD_DW];
    logic [10:0] pidx;
    logic        trunc;
    logic        disc;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [10:0] dwc;
    logic [7:0]  drop_cnt;

    logic [31:0] dw [NK];
    int          beat_cnt;
    int          src;
    int          off;
    int          sum;
    logic [31:0] cap_pld [MAX_PLD_DW];
    logic        cap_trunc;
    logic [10:0] cap_pidx;
    logic [31:0] app_pld [MAX_PLD_DW];
    logic        app_trunc;
    logic [10:0] app_pidx;

    logic [REC_W-1:0] rec_w;
    logic [31:0]      ex_w;

    logic [REC_W-1:0] mem    [FIFO_DEPTH];
    logic [31:0]      mem_ex [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [REC_W-1:0] last_data;
    logic [31:0]      last_ex;

    logic accept;
    logic sop;
    logic push;
    logic pop;
    logic unused_user;

    assign accept      = m_axis_cq_tvalid & m_axis_cq_tready;
    assign sop         = m_axis_cq_tuser[40];
    assign push        = (state == COMMIT);
    assign pop         = cq_rec_valid & cq_rec_ready;
    assign unused_user = ^{m_axis_cq_tuser[87:42], m_axis_cq_tuser[39:8]};

    // Beat slicing: payload placement for a fresh TLP and for an appended beat
    always_comb begin
        beat_cnt = 0;
        src      = 0;
        off      = 0;
        sum      = 0;
        for (int k = 0; k < NK; k++) begin
            dw[k] = m_axis_cq_tdata[32*k +: 32];
            if (m_axis_cq_tkeep[k]) beat_cnt = beat_cnt + 1;
        end
        for (int j = 0; j < MAX_PLD_DW; j++) begin
            cap_pld[j] = '0;
            src = j + 4;
            if (src < beat_cnt) cap_pld[j] = dw[KW'(src)];
            app_pld[j] = pld[j];
            off = j - int'(pidx);
            if (off >= 0 && off < beat_cnt) app_pld[j] = dw[KW'(off)];
        end
        cap_trunc = (beat_cnt - 4) > MAX_PLD_DW;
        cap_pidx  = (beat_cnt > 4) ? 11'(beat_cnt - 4) : 11'd0;
        sum       = int'(pidx) + beat_cnt;
        app_trunc = trunc | (sum > MAX_PLD_DW);
        app_pidx  = (sum > 2047) ? 11'd2047 : 11'(sum);
    end

    // Record image presented to the FIFO while in COMMIT
    always_comb begin
        rec_w        = '0;
        rec_w[127:0] = desc;
        for (int j = 0; j < MAX_PLD_DW; j++)
            rec_w[128 + 32*j +: 32] = pld[j];
        ex_w = {disc, trunc, fbe, lbe, dwc, pidx};
    end

    // Assembler FSM: capture on sop, append in COLLECT, commit after tlast
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state    <= IDLE;
            desc     <= '0;
            pidx     <= '0;
            trunc    <= 1'b0;
            disc     <= 1'b0;
            fbe      <= '0;
            lbe      <= '0;
            dwc      <= '0;
            drop_cnt <= '0;
            for (int j = 0; j < MAX_PLD_DW; j++) pld[j] <= '0;
        end else if (accept && sop) begin
            desc  <= m_axis_cq_tdata[127:0];
            fbe   <= m_axis_cq_tuser[3:0];
            lbe   <= m_axis_cq_tuser[7:4];
            disc  <= m_axis_cq_tuser[41];
            dwc   <= m_axis_cq_tdata[74:64];
            pidx  <= cap_pidx;
            trunc <= cap_trunc;
            for (int j = 0; j < MAX_PLD_DW; j++) pld[j] <= cap_pld[j];
            if (state == COLLECT && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
            state <= m_axis_cq_tlast ? COMMIT : COLLECT;
        end else if (accept && state == COLLECT) begin
            pidx  <= app_pidx;
            trunc <= app_trunc;
            disc  <= disc | m_axis_cq_tuser[41];
            for (int j = 0; j < MAX_PLD_DW; j++) pld[j] <= app_pld[j];
            if (m_axis_cq_tlast) state <= COMMIT;
        end else if (state == COMMIT) begin
            state <= IDLE;
        end
    end

    // Record storage; left unreset since reads are gated by level
    always_ff @(posedge pcie_clk) begin
        if (push) begin
            mem[wr_ptr]    <= rec_w;
            mem_ex[wr_ptr] <= ex_w;
        end
    end

    // FIFO pointers, level and last-popped hold registers
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            last_data <= '0;
            last_ex   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr];
                last_ex   <= mem_ex[rd_ptr];
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Registered tready keeps one slot free for the TLP in flight
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst)
            m_axis_cq_tready <= 1'b0;
        else
            m_axis_cq_tready <= (int'(level) + int'(push)) <= (FIFO_DEPTH - 2);
    end

    assign cq_rec_valid = (level != '0);
    assign cq_rec_data  = cq_rec_valid ? mem[rd_ptr] : last_data;
    assign cq_rec_ex    = cq_rec_valid ? mem_ex[rd_ptr] : last_ex;
    assign odbg_info    = {drop_cnt, 4'(level), 2'b00,
                           cq_rec_valid, m_axis_cq_tready};

`ifdef PCIE_CQ_STAT_EN
    logic [31:0] st_rec;
    logic [15:0] st_disc;
    logic [15:0] st_trunc;

    // Wrapping statistics; clear wins over a same-cycle increment
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst || cq_stat_clr) begin
            st_rec   <= '0;
            st_disc  <= '0;
            st_trunc <= '0;
        end else if (push) begin
            st_rec <= st_rec + 32'd1;
            if (disc)  st_disc  <= st_disc + 16'd1;
            if (trunc) st_trunc <= st_trunc + 16'd1;
        end
    end

    assign cq_stat = {st_rec, st_disc, st_trunc};
`endif

endmodule

// File: tb/tb_pcie_cq_rx_fifo.sv
// Directed bench for pcie_cq_rx_fifo with default parameters.
// Covers latency, truncation, backpressure, drop and reset flush.
module tb_pcie_cq_rx_fifo;

    localparam int DW    = 256;
    localparam int MAXP  = 8;
    localparam int DEPTH = 4;
    localparam int RW    = 128 + 32 * MAXP;

    logic            pcie_clk = 1'b0;
    logic            pcie_rst;
    logic [DW-1:0]   tdata;
    logic [87:0]     tuser;
    logic [DW/32-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;
    logic [RW-1:0]   rec;
    logic [31:0]     ex;
    logic            rvalid;
    logic            rready;
    logic [15:0]     dbg;
`ifdef PCIE_CQ_STAT_EN
    logic            stat_clr = 1'b0;
    logic [63:0]     stat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 pcie_clk = ~pcie_clk;

    pcie_cq_rx_fifo #(
        .DWIDTH(DW), .MAX_PLD_DW(MAXP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .pcie_clk(pcie_clk),
        .pcie_rst(pcie_rst),
        .m_axis_cq_tdata(tdata),
        .m_axis_cq_tuser(tuser),
        .m_axis_cq_tkeep(tkeep),
        .m_axis_cq_tlast(tlast),
        .m_axis_cq_tvalid(tvalid),
        .m_axis_cq_tready(tready),
        .cq_rec_data(rec),
        .cq_rec_ex(ex),
        .cq_rec_valid(rvalid),
        .cq_rec_ready(rready),
`ifdef PCIE_CQ_STAT_EN
        .cq_stat_clr(stat_clr),
        .cq_stat(stat),
`endif
        .odbg_info(dbg)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_desc(input logic [10:0] dwc,
                                             input logic [31:0] id);
        return {id, 21'h0, dwc, 32'h0, 32'h1000_0000};
    endfunction

    function automatic logic [87:0] mk_user(input logic [3:0] fbe,
                                            input logic [3:0] lbe,
                                            input logic s,
                                            input logic d);
        logic [87:0] u;
        u      = '0;
        u[3:0] = fbe;
        u[7:4] = lbe;
        u[40]  = s;
        u[41]  = d;
        return u;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [DW-1:0] d, input logic [87:0] u,
                        input logic [7:0] k, input logic l);
        int w;
        tdata  = d;
        tuser  = u;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        w = 0;
        while (!tready && w < 500) begin
            @(negedge pcie_clk);
            w++;
        end
        chk("accept", {63'h0, tready}, 64'h1);
        @(negedge pcie_clk);
        tvalid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!rvalid && w < 20) begin
            @(negedge pcie_clk);
            w++;
        end
        chk(tag, {63'h0, rvalid}, 64'h1);
    endtask

    task automatic pop_one();
        rready = 1'b1;
        @(negedge pcie_clk);
        rready = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_trdy"}, {63'h0, tready}, 64'h0);
        chk({tag, "_vld"}, {63'h0, rvalid}, 64'h0);
        chk({tag, "_ex"}, {32'h0, ex}, 64'h0);
        chk({tag, "_data"}, {63'h0, |rec}, 64'h0);
        chk({tag, "_dbg"}, {48'h0, dbg}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int n;
        pcie_rst = 1'b1;
        tdata    = '0;
        tuser    = '0;
        tkeep    = '0;
        tlast    = 1'b0;
        tvalid   = 1'b0;
        rready   = 1'b0;
        repeat (3) @(negedge pcie_clk);
        reset_chk("rst0");
        pcie_rst = 1'b0;
        @(negedge pcie_clk);

        // T1: single-beat MWr 1DW
        d = {96'h0, 32'hA5A5_0001, mk_desc(11'd1, 32'h11)};
        send(d, mk_user(4'hF, 4'h0, 1'b1, 1'b0), 8'h1f, 1'b1);
        chk("t1_lat1", {63'h0, rvalid}, 64'h0);
        @(negedge pcie_clk);
        chk("t1_lat2", {63'h0, rvalid}, 64'h1);
        chk("t1_pld0", {32'h0, rec[159:128]}, 64'hA5A5_0001);
        chk("t1_id", {32'h0, rec[127:96]}, 64'h11);
        chk("t1_cnt", {53'h0, ex[10:0]}, 64'd1);
        chk("t1_dwc", {53'h0, ex[21:11]}, 64'd1);
        chk("t1_flags", {62'h0, ex[31:30]}, 64'h0);
        pop_one();
        chk("t1_empty", {63'h0, rvalid}, 64'h0);
        chk("t1_hold", {32'h0, rec[159:128]}, 64'hA5A5_0001);

        // T2: MRd, upper dwords carry junk masked by tkeep
        d = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
             mk_desc(11'd4, 32'h22)};
        send(d, mk_user(4'hF, 4'hF, 1'b1, 1'b0), 8'h0f, 1'b1);
        wait_valid("t2_vld");
        chk("t2_pld", {63'h0, |rec[RW-1:128]}, 64'h0);
        chk("t2_cnt", {53'h0, ex[10:0]}, 64'd0);
        chk("t2_fbe", {60'h0, ex[29:26]}, 64'hF);
        chk("t2_lbe", {60'h0, ex[25:22]}, 64'hF);
        chk("t2_dwc", {53'h0, ex[21:11]}, 64'd4);
        pop_one();

        // T3: MWr 12DW truncated to 8, discontinue on the tail
        d = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000,
             mk_desc(11'd12, 32'h33)};
        send(d, mk_user(4'hF, 4'hF, 1'b1, 1'b0), 8'hff, 1'b0);
        for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'hC000_0004 + k;
        send(d, mk_user(4'h0, 4'h0, 1'b0, 1'b1), 8'hff, 1'b1);
        wait_valid("t3_vld");
        chk("t3_cnt", {53'h0, ex[10:0]}, 64'd12);
        chk("t3_trunc", {63'h0, ex[30]}, 64'h1);
        chk("t3_disc", {63'h0, ex[31]}, 64'h1);
        chk("t3_dwc", {53'h0, ex[21:11]}, 64'd12);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3_pld%0d", k), {32'h0, rec[128 + 32*k +: 32]},
                64'hC000_0000 + 64'(k));
        pop_one();

        // T4: backpressure with five back-to-back TLPs
        n = 0;
        fork
            begin
                logic [DW-1:0] b;
                for (int i = 0; i < 5; i++) begin
                    b = {96'h0, 32'hD000_0000 + i, mk_desc(11'd1, 32'h40 + i)};
                    send(b, mk_user(4'hF, 4'h0, 1'b1, 1'b0), 8'h1f, 1'b1);
                end
            end
            begin
                repeat (20) @(negedge pcie_clk);
                chk("t4_trdy", {63'h0, tready}, 64'h0);
                chk("t4_lvl", {60'h0, dbg[7:4]}, 64'd4);
                chk("t4_vld", {63'h0, rvalid}, 64'h1);
                rready = 1'b1;
                for (int c = 0; c < 100 && n < 5; c++) begin
                    if (rvalid) begin
                        chk($sformatf("t4_ord%0d", n), {32'h0, rec[159:128]},
                            64'hD000_0000 + 64'(n));
                        n++;
                    end
                    @(negedge pcie_clk);
                end
                rready = 1'b0;
            end
        join
        chk("t4_n", 64'(n), 64'd5);
        repeat (3) @(negedge pcie_clk);
        chk("t4_empty", {63'h0, rvalid}, 64'h0);
        chk("t4_lvl0", {60'h0, dbg[7:4]}, 64'd0);

        // T5: partial TLP overrun by a new sop
        d = {128'h0, mk_desc(11'd8, 32'h5A)};
        send(d, mk_user(4'hF, 4'hF, 1'b1, 1'b0), 8'hff, 1'b0);
        d = {96'h0, 32'hE000_0001, mk_desc(11'd1, 32'h5B)};
        send(d, mk_user(4'hF, 4'h0, 1'b1, 1'b0), 8'h1f, 1'b1);
        wait_valid("t5_vld");
        chk("t5_id", {32'h0, rec[127:96]}, 64'h5B);
        chk("t5_cnt", {53'h0, ex[10:0]}, 64'd1);
        chk("t5_drop", {56'h0, dbg[15:8]}, 64'd1);
        pop_one();
        repeat (4) @(negedge pcie_clk);
        chk("t5_one", {63'h0, rvalid}, 64'h0);

        // T6: reset with a queued record and a TLP in flight
        d = {96'h0, 32'hF000_0001, mk_desc(11'd1, 32'h61)};
        send(d, mk_user(4'hF, 4'h0, 1'b1, 1'b0), 8'h1f, 1'b1);
        repeat (3) @(negedge pcie_clk);
        chk("t6_q", {63'h0, rvalid}, 64'h1);
        d = {128'h0, mk_desc(11'd8, 32'h62)};
        send(d, mk_user(4'hF, 4'hF, 1'b1, 1'b0), 8'hff, 1'b0);
        pcie_rst = 1'b1;
        repeat (2) @(negedge pcie_clk);
        reset_chk("rst1");
        pcie_rst = 1'b0;
        d = {256'h0};
        send(d, mk_user(4'h0, 4'h0, 1'b0, 1'b0), 8'hff, 1'b1);
        repeat (5) @(negedge pcie_clk);
        chk("t6_tail", {63'h0, rvalid}, 64'h0);
        d = {96'h0, 32'hF000_0003, mk_desc(11'd1, 32'h63)};
        send(d, mk_user(4'hF, 4'h0, 1'b1, 1'b0), 8'h1f, 1'b1);
        wait_valid("t6_vld");
        chk("t6_id", {32'h0, rec[127:96]}, 64'h63);
        chk("t6_drop", {56'h0, dbg[15:8]}, 64'd0);
        pop_one();
        repeat (3) @(negedge pcie_clk);
        chk("t6_empty", {63'h0, rvalid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
